// File: rtl/alu_md_controller.sv
// alu_md_controller: RV32I aluop decode plus an iterative RV32M multiply/divide engine
// with a pipeline stall handshake.
module alu_md_controller #(
    parameter int XLEN        = 32,
    parameter int ALUOPWIDTH  = 4,
    parameter int FUNCT3WIDTH = 3,
    parameter int FUNCT7WIDTH = 7,
    parameter int OPCODEWIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   flush,
    input  logic [OPCODEWIDTH-1:0] op,
    input  logic [FUNCT3WIDTH-1:0] func3,
    input  logic [FUNCT7WIDTH-1:0] func7,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    output logic [ALUOPWIDTH-1:0]  aluop,
    output logic                   md_stall,
    output logic                   md_valid,
    output logic [XLEN-1:0]        md_result
);
    localparam int cw = $clog2(XLEN);
    localparam logic [OPCODEWIDTH-1:0] rtype = OPCODEWIDTH'(7'b0110011);
    localparam logic [OPCODEWIDTH-1:0] itype = OPCODEWIDTH'(7'b0010011);
    localparam logic [FUNCT7WIDTH-1:0] f7_alt = FUNCT7WIDTH'(7'b0100000);
    localparam logic [FUNCT7WIDTH-1:0] f7_md = FUNCT7WIDTH'(7'b0000001);
    localparam logic [XLEN-1:0] xmin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {st_idle, st_mul, st_div, st_done} state_t;
    state_t state, state_nx;

    logic [cw-1:0]          cnt;
    logic [2*XLEN-1:0]      prod;
    logic [XLEN-1:0]        opd, held, a_mag, b_mag, fin, qv, rv;
    logic [2*XLEN-1:0]      pn;
    logic [FUNCT3WIDTH-1:0] f3;
    logic                   neg_q, neg_r;
    logic                   is_md, start, div_in, a_neg, b_neg, special, last;
    logic [XLEN:0]          mul_sum, div_diff;

    always_comb begin
        aluop = ALUOPWIDTH'(0);
        if ((op == rtype || op == itype) && !(op == rtype && func7 == f7_md))
            case (func3[2:0])
                3'b000: aluop = (op == rtype && func7 == f7_alt) ? ALUOPWIDTH'(1) : ALUOPWIDTH'(0);
                3'b001: aluop = ALUOPWIDTH'(2);
                3'b010: aluop = ALUOPWIDTH'(3);
                3'b011: aluop = ALUOPWIDTH'(4);
                3'b100: aluop = ALUOPWIDTH'(5);
                3'b101: aluop = (func7 == f7_alt) ? ALUOPWIDTH'(7) : ALUOPWIDTH'(6);
                3'b110: aluop = ALUOPWIDTH'(8);
                default: aluop = ALUOPWIDTH'(9);
            endcase
    end

    assign is_md   = (op == rtype) && (func7 == f7_md);
    assign start   = in_valid && is_md && !flush && state == st_idle;
    assign div_in  = func3[2];
    // MUL (000) is treated as signed x signed: the low half is sign-agnostic
    assign a_neg   = (div_in ? !func3[0] : func3[1:0] != 2'b11) && rs1_data[XLEN-1];
    assign b_neg   = (div_in ? !func3[0] : !func3[1]) && rs2_data[XLEN-1];
    assign a_mag   = a_neg ? -rs1_data : rs1_data;
    assign b_mag   = b_neg ? -rs2_data : rs2_data;
    assign special = div_in && (rs2_data == '0 || (!func3[0] && rs1_data == xmin && &rs2_data));
    assign last    = cnt == cw'(XLEN - 1);

    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opd} : '0);
    assign div_diff = prod[2*XLEN-1:XLEN-1] - {1'b0, opd};

    assign pn  = neg_q ? -prod : prod;
    assign qv  = prod[XLEN-1:0];
    assign rv  = prod[2*XLEN-1:XLEN];
    assign fin = f3[2] ? (f3[1] ? (neg_r ? -rv : rv) : (neg_q ? -qv : qv))
                       : (f3[1:0] == 2'b00 ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= st_idle;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = st_idle;
        else
            case (state)
                st_idle: if (start) state_nx = special ? st_done : (div_in ? st_div : st_mul);
                st_mul, st_div: if (last) state_nx = st_done;
                default: state_nx = st_idle;
            endcase
    end

    always_comb begin
        md_stall  = start || state == st_mul || state == st_div;
        md_valid  = state == st_done && !flush;
        md_result = md_valid ? fin : held;
    end

    // Special divides preload prod so the normal quotient/remainder select yields the fixed answer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            prod  <= '0;
            opd   <= '0;
            f3    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            held  <= '0;
        end else begin
            if (start) begin
                cnt   <= '0;
                f3    <= func3;
                opd   <= div_in ? b_mag : a_mag;
                neg_q <= !special && (a_neg ^ b_neg);
                neg_r <= !special && a_neg;
                prod  <= special ? (rs2_data == '0 ? {rs1_data, {XLEN{1'b1}}} : {{XLEN{1'b0}}, xmin})
                                 : {{XLEN{1'b0}}, div_in ? a_mag : b_mag};
            end else if (state == st_mul || state == st_div) begin
                cnt  <= cnt + cw'(1);
                prod <= state == st_mul ? {mul_sum, prod[XLEN-1:1]}
                      : (div_diff[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                                        : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1});
            end
            if (md_valid)
                held <= fin;
        end
    end
endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller: directed and randomized checks of aluop decode and the M-extension engine
// against an arithmetic reference model.
module tb_alu_md_controller;
    localparam int XLEN = 32;
    localparam logic [6:0] op_r = 7'b0110011;
    localparam logic [6:0] op_i = 7'b0010011;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, flush;
    logic [6:0]        op, func7;
    logic [2:0]        func3;
    logic [XLEN-1:0]   rs1_data, rs2_data, md_result;
    logic [3:0]        aluop;
    logic              md_stall, md_valid;

    int n_asserts = 0;
    int n_fail = 0;

    alu_md_controller dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
        .op(op), .func3(func3), .func7(func7),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .aluop(aluop), .md_stall(md_stall), .md_valid(md_valid), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_aluop(input logic [6:0] o, input logic [2:0] f, input logic [6:0] f7);
        int f3map[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (o != op_r && o != op_i) return 4'd0;
        if (o == op_r && f7 == 7'b0000001) return 4'd0;
        if (f == 3'b000 && o == op_r && f7 == 7'b0100000) return 4'd1;
        if (f == 3'b101 && f7 == 7'b0100000) return 4'd7;
        return 4'(f3map[f]);
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        op = op_r;
        func7 = 7'b0000001;
        func3 = f;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
    endtask

    task automatic do_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int stalls, vcyc, pulses, elat;
        logic [31:0] res;
        elat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : XLEN + 1;
        @(negedge clk);
        issue(f, a, b);
        #1;
        stalls = 0;
        vcyc = -1;
        pulses = 0;
        res = 'x;
        for (int k = 0; k < XLEN + 8; k++) begin
            if (md_stall) stalls++;
            if (md_valid) begin
                pulses++;
                if (vcyc < 0) begin
                    vcyc = k;
                    res = md_result;
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
        end
        chk($sformatf("md_result f3=%0d a=%h b=%h", f, a, b), res, exp);
        chk($sformatf("valid_cycle f3=%0d", f), vcyc, elat);
        chk($sformatf("stall_cycles f3=%0d", f), stalls, elat);
        chk($sformatf("valid_pulses f3=%0d", f), pulses, 1);
        chk("held_after_done", md_result, exp);
    endtask

    initial begin
        logic [2:0] rf;
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        op = '0;
        func3 = '0;
        func7 = '0;
        rs1_data = '0;
        rs2_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", md_stall, 0);
        chk("reset_valid", md_valid, 0);
        chk("reset_result", md_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_stall", md_stall, 0);

        op = op_r; func3 = 3'b000; func7 = 7'b0100000; #1 chk("dec_r_sub", aluop, 4'd1);
        op = op_i; #1 chk("dec_i_add", aluop, 4'd0);
        op = op_r; func3 = 3'b101; #1 chk("dec_r_sra", aluop, 4'd7);
        op = op_i; #1 chk("dec_i_sra", aluop, 4'd7);
        op = 7'b0000011; #1 chk("dec_load", aluop, 4'd0);
        op = op_r; func7 = 7'b0000001; func3 = 3'b110; #1 chk("dec_m_add", aluop, 4'd0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: op = op_r;
                1: op = op_i;
                2: op = 7'b0000011;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: func7 = 7'b0000000;
                1: func7 = 7'b0100000;
                2: func7 = 7'b0000001;
                default: func7 = 7'($urandom);
            endcase
            func3 = 3'($urandom);
            #1 chk($sformatf("dec_rand op=%b f3=%b f7=%b", op, func3, func7), aluop, ref_aluop(op, func3, func7));
        end
        op = '0;

        do_md(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        do_md(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        do_md(3'd3, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002);
        do_md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_md(3'd5, 32'd100, 32'd7, 32'd14);
        do_md(3'd7, 32'd100, 32'd7, 32'd2);
        do_md(3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF);
        do_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            do_md(rf, ra, rb, md_ref(rf, ra, rb));
        end

        @(negedge clk);
        issue(3'd0, 32'd9, 32'd9);
        flush = 1'b1;
        #1 chk("flush_blocks_start", md_stall, 0);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        #1 chk("flush_blocks_start_next", md_stall, 0);

        do_md(3'd0, 32'd5, 32'd6, 32'd30);
        @(negedge clk);
        issue(3'd1, $urandom, $urandom);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1;
        #1 chk("flush_cycle_stall", md_stall, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_stall", md_stall, 0);
        chk("post_flush_valid", md_valid, 0);
        chk("post_flush_result", md_result, 32'd30);
        do_md(3'd5, 32'd100, 32'd7, 32'd14);

        @(negedge clk);
        issue(3'd4, 32'd1000, 32'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_reset_stall", md_stall, 0);
        chk("mid_reset_valid", md_valid, 0);
        chk("mid_reset_result", md_result, 0);
        do_md(3'd4, 32'd1000, 32'd3, 32'd333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
